explosion_scheduler: RTL and testbench
======================================

# explosion_scheduler

Sequences the destroy (explosion) sprite renderer. Collision logic posts hit coordinates. This block queues them in a small FIFO and plays one explosion at a time. For each explosion it drives `destroy`, `dH` and `dV` for a fixed number of video frames, then holds a short blank gap before the next one. Updates happen only on frame boundaries, so the renderer never sees coordinates change mid-frame.

## Interface
Parameters:
- `DEPTH`, 4: pending-hit FIFO depth; power of two, 2..16.
- `FRAMES`, 30: frames each explosion is displayed; 1..255.
- `GAP_FRAMES`, 2: blank frames between explosions; 0..255.

Ports:
- `clk` in 1: pixel/system clock; the only clock.
- `resetn` in 1: asynchronous, active-low reset.
- `frameTick` in 1: one-cycle pulse at the start of vertical blank.
- `hitValid` in 1: a hit is offered.
- `hitH` in 10: hit pixel column, 0..639.
- `hitV` in 10: hit pixel row, 0..479.
- `hitReady` out 1: FIFO can accept; a push happens when `hitValid && hitReady`.
- `destroy` out 1: enables the renderer.
- `dH` out 33: explosion centre column, zero-extended.
- `dV` out 33: explosion centre row, zero-extended.
- `frameCount` out 8: frame index within the current explosion.
- `busy` out 1: high when state ≠ IDLE or the FIFO is non-empty.

## Operation
- **Clock and reset**: one clock; reset is asynchronous and active-low.
- **Reset values**:
  - State IDLE, FIFO empty, all counters 0.
  - `destroy`=0, `dH`=0, `dV`=0, `frameCount`=0, `busy`=0, `hitReady`=1.
- **FIFO**:
  - `hitReady` = !full, decoded from the registered count only.
  - When full, a push is refused even if a pop happens in the same cycle.
  - Push and pop in the same cycle while not full: count unchanged.
- **Clamping on push**: clamp applied before storing, so the renderer's ±20 box never wraps.
  - H is clamped to 20..619.
  - V is clamped to 20..459.
- **IDLE**:
  - `destroy`=0.
  - If the FIFO is non-empty: pop, load `dH`/`dV` from the head entry, go to ARM.
- **ARM**:
  - `destroy`=0; waits for `frameTick`.
  - On `frameTick`: go to ACTIVE, `frameCount`=0.
- **ACTIVE**:
  - `destroy`=1, subject to the Configuration section.
  - On each `frameTick`: if `frameCount`==FRAMES-1, go to GAP (or to IDLE when GAP_FRAMES=0) and clear `frameCount`; otherwise increment `frameCount`.
- **GAP**:
  - `destroy`=0; counts `frameTick` pulses in an internal gap counter.
  - On the GAP_FRAMES-th tick: go to IDLE.
- **Coordinate holding**: `dH`/`dV` keep their last value outside ACTIVE and change only on a load in IDLE.
- **Hits while playing**: they queue and never pre-empt the current explosion.
- **Reset mid-operation**: returns immediately to the reset values above; queued hits are discarded.

## Timing
- **Push to load**: a push accepted at edge N can be popped at N+1 when the FIFO was empty (IDLE pop). `dH`/`dV` are valid at N+2.
- **Latency from load to display**: the first `frameTick` after ARM is entered. `destroy` rises in the cycle after that tick.
- **Display length**: exactly FRAMES frame periods; `destroy` falls in the cycle after the FRAMES-th tick counted in ACTIVE.
- **Tick during IDLE pop**: ignored; ARM waits for the next tick.
- **Outputs**: all are registered, except `hitReady` and `busy`, which are decoded from registers only.
- **Counter widths**: 8-bit counters; no wrap, because compares terminate them at the parameter limits.

## Configuration
- `EXPLODE_BLINK_EN` defined: in ACTIVE, `destroy` = !`frameCount`[0], giving a blink on even frames.
- Without `EXPLODE_BLINK_EN`: `destroy` stays constant 1 throughout ACTIVE.
- State timing is identical in both builds.

## Test plan
- **Single hit**: push (300,200) in IDLE with FRAMES=30 →
  - `dH`=300, `dV`=200 two cycles later;
  - `destroy` rises the cycle after the next tick and stays high for 30 ticks;
  - then 2 gap ticks, then `busy`=0.
- **Clamping**: push (5,470) → `dH`=20, `dV`=459. Push (639,0) → `dH`=619, `dV`=20.
- **Back-pressure**: 5 pushes while ACTIVE with DEPTH=4 →
  - `hitReady` drops after the 4th push; the 5th is held and not lost;
  - it is accepted in the cycle after the next pop;
  - explosions play in push order.
- **Push/pop collision**: FIFO full and a pop in the same cycle → push refused. FIFO at count 2 with simultaneous push and pop → count stays 2.
- **Reset mid-ACTIVE**: assert `resetn`=0 at `frameCount`=10 → `destroy`=0, `dH`=0, `dV`=0 with no clock edge; FIFO empty after release.
- **Blink build**: with `EXPLODE_BLINK_EN` defined → `destroy` is high on frames 0, 2, 4, … and low on odd frames; GAP entry is still on the 30th tick.

Source files
------------

// File: rtl/explosion_scheduler.sv
// Queues collision hits and plays one explosion at a time on frame boundaries.
// Optional build macro: EXPLODE_BLINK_EN (destroy blinks on odd frames while active).
module explosion_scheduler #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned FRAMES     = 30,
    parameter int unsigned GAP_FRAMES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        frameTick,
    input  logic        hitValid,
    input  logic [9:0]  hitH,
    input  logic [9:0]  hitV,
    output logic        hitReady,
    output logic        destroy,
    output logic [32:0] dH,
    output logic [32:0] dV,
    output logic [7:0]  frameCount,
    output logic        busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        ACTIVE,
        GAP
    } state_t;

    state_t        state;
    logic [9:0]    mem_h [DEPTH];
    logic [9:0]    mem_v [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    gap_cnt;
    logic [7:0]    fc_next;
    logic [9:0]    clamp_h;
    logic [9:0]    clamp_v;
    logic          full;
    logic          push;
    logic          pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign hitReady = !full;
    assign push     = hitValid && !full;
    assign pop      = (state == IDLE) && (count != '0);
    assign busy     = (state != IDLE) || (count != '0);
    assign fc_next  = frameCount + 8'd1;

    // Clamp before storing so the renderer's +/-20 box never wraps.
    always_comb begin
        clamp_h = hitH;
        clamp_v = hitV;
        if (hitH < 10'd20)
            clamp_h = 10'd20;
        else if (hitH > 10'd619)
            clamp_h = 10'd619;
        if (hitV < 10'd20)
            clamp_v = 10'd20;
        else if (hitV > 10'd459)
            clamp_v = 10'd459;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_h[wr_ptr] <= clamp_h;
            mem_v[wr_ptr] <= clamp_v;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            destroy    <= 1'b0;
            dH         <= '0;
            dV         <= '0;
            frameCount <= '0;
            gap_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    destroy <= 1'b0;
                    if (pop) begin
                        dH    <= 33'(mem_h[rd_ptr]);
                        dV    <= 33'(mem_v[rd_ptr]);
                        state <= ARM;
                    end
                end
                ARM: begin
                    destroy <= 1'b0;
                    if (frameTick) begin
                        state      <= ACTIVE;
                        frameCount <= '0;
                        destroy    <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (frameTick) begin
                        if (frameCount == 8'(FRAMES - 1)) begin
                            frameCount <= '0;
                            destroy    <= 1'b0;
                            gap_cnt    <= '0;
                            state      <= (GAP_FRAMES == 0) ? IDLE : GAP;
                        end else begin
                            frameCount <= fc_next;
`ifdef EXPLODE_BLINK_EN
                            destroy    <= ~fc_next[0];
`else
                            destroy    <= 1'b1;
`endif
                        end
                    end
                end
                GAP: begin
                    destroy <= 1'b0;
                    if (frameTick) begin
                        if (gap_cnt == 8'(GAP_FRAMES - 1)) begin
                            gap_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_explosion_scheduler.sv
// Directed bench for explosion_scheduler: scoreboard of clamped hit coordinates in push order.
module tb_explosion_scheduler;

    localparam int unsigned FR = 30;
    localparam int unsigned GF = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        frameTick = 1'b0;
    logic        hitValid = 1'b0;
    logic [9:0]  hitH = '0;
    logic [9:0]  hitV = '0;
    logic        hitReady;
    logic        destroy;
    logic [32:0] dH;
    logic [32:0] dV;
    logic [7:0]  frameCount;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [19:0] sb[$];
    logic [9:0]  cur_h = '0;
    logic [9:0]  cur_v = '0;

    explosion_scheduler #(
        .DEPTH(4),
        .FRAMES(FR),
        .GAP_FRAMES(GF)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .frameTick(frameTick),
        .hitValid(hitValid),
        .hitH(hitH),
        .hitV(hitV),
        .hitReady(hitReady),
        .destroy(destroy),
        .dH(dH),
        .dV(dV),
        .frameCount(frameCount),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] clampv(input logic [9:0] x, input logic [9:0] lo, input logic [9:0] hi);
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

    function automatic logic exp_destroy(input int unsigned k);
`ifdef EXPLODE_BLINK_EN
        return (k % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frameTick = 1'b1;
        step(1);
        frameTick = 1'b0;
    endtask

    task automatic push(input logic [9:0] h, input logic [9:0] v);
        check("push_ready", hitReady, 1);
        hitValid = 1'b1;
        hitH = h;
        hitV = v;
        step(1);
        hitValid = 1'b0;
        sb.push_back({clampv(h, 10'd20, 10'd619), clampv(v, 10'd20, 10'd459)});
    endtask

    // Entered with the head already loaded (ARM); issues the tick that starts display.
    task automatic start();
        logic [19:0] e;
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            cur_h = e[19:10];
            cur_v = e[9:0];
        end
        check("load_dH", dH, cur_h);
        check("load_dV", dV, cur_v);
        check("arm_destroy", destroy, 0);
        check("arm_busy", busy, 1);
        step(2);
        check("arm_wait_destroy", destroy, 0);
        tick();
        check("act0_destroy", destroy, exp_destroy(0));
        check("act0_fc", frameCount, 0);
    endtask

    task automatic run(input int unsigned last);
        for (int unsigned k = 1; k <= last; k++) begin
            step(3);
            tick();
            if (k == FR) begin
                check("end_destroy", destroy, 0);
                check("end_fc", frameCount, 0);
                check("end_busy", busy, 1);
            end else begin
                check("act_fc", frameCount, k);
                check("act_destroy", destroy, exp_destroy(k));
            end
        end
    endtask

    task automatic gap();
        step(3);
        tick();
        check("gap_busy", busy, 1);
        check("gap_destroy", destroy, 0);
        check("gap_dH_hold", dH, cur_h);
        step(3);
        tick();
        check("gap_done_busy", busy, sb.size() != 0);
        check("gap_done_destroy", destroy, 0);
    endtask

    initial begin
        step(2);
        check("rst_destroy", destroy, 0);
        check("rst_dH", dH, 0);
        check("rst_dV", dV, 0);
        check("rst_fc", frameCount, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", hitReady, 1);
        resetn = 1'b1;
        step(2);

        // single hit
        push(10'd300, 10'd200);
        step(1);
        start();
        run(FR);
        gap();
        check("single_idle_busy", busy, 0);

        // clamping low-H / high-V
        push(10'd5, 10'd470);
        step(1);
        start();
        run(FR);
        gap();

        // clamping high-H / low-V, with a tick landing on the IDLE pop edge
        push(10'd639, 10'd0);
        tick();
        start();
        run(FR);
        gap();

        // back-pressure: four queued during ACTIVE, fifth held while full
        push(10'd100, 10'd100);
        step(1);
        start();
        push(10'd110, 10'd120);
        push(10'd210, 10'd220);
        push(10'd310, 10'd320);
        push(10'd410, 10'd420);
        check("bp_full_ready", hitReady, 0);
        hitValid = 1'b1;
        hitH = 10'd510;
        hitV = 10'd450;
        run(FR);
        gap();
        check("bp_still_full", hitReady, 0);
        step(1);
        check("bp_pop_refuse", hitReady, 1);
        step(1);
        check("bp_held_accept", hitReady, 0);
        hitValid = 1'b0;
        sb.push_back({10'd510, 10'd450});
        for (int i = 0; i < 5; i++) begin
            start();
            run(FR);
            gap();
            if (i < 4) step(1);
        end
        check("bp_idle_busy", busy, 0);

        // simultaneous push and pop at count 2
        push(10'd150, 10'd160);
        step(1);
        start();
        push(10'd250, 10'd260);
        push(10'd350, 10'd360);
        run(FR);
        step(3);
        tick();
        step(3);
        tick();
        hitValid = 1'b1;
        hitH = 10'd450;
        hitV = 10'd400;
        step(1);
        hitValid = 1'b0;
        sb.push_back({10'd450, 10'd400});
        check("pp_ready_cnt2", hitReady, 1);
        push(10'd550, 10'd440);
        check("pp_ready_cnt3", hitReady, 1);
        push(10'd600, 10'd30);
        check("pp_ready_cnt4", hitReady, 0);
        for (int i = 0; i < 5; i++) begin
            start();
            run(FR);
            gap();
            if (i < 4) step(1);
        end
        check("pp_idle_busy", busy, 0);

        // asynchronous reset mid-ACTIVE
        push(10'd400, 10'd300);
        step(1);
        start();
        run(10);
        push(10'd50, 10'd60);
        #2;
        resetn = 1'b0;
        #1;
        check("amid_destroy", destroy, 0);
        check("amid_dH", dH, 0);
        check("amid_dV", dV, 0);
        check("amid_fc", frameCount, 0);
        check("amid_busy", busy, 0);
        check("amid_ready", hitReady, 1);
        sb.delete();
        step(2);
        resetn = 1'b1;
        step(3);
        check("post_busy", busy, 0);
        tick();
        step(2);
        check("post_destroy", destroy, 0);
        check("post_dH", dH, 0);
        check("post_busy2", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
